// File: rtl/lut_neuron_array_pkg.sv
// rtl/lut_neuron_array_pkg.sv - shared state encoding and sizing helper for the LUT neuron array
package lut_neuron_array_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Never returns 0 so a single-neuron array still gets a 1-bit id port.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lut_neuron.sv
// rtl/lut_neuron.sv - one run-time loadable truth table: synchronous write, combinational read
module lut_neuron #(
    parameter int ADDR_W   = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [OUT_BITS-1:0] rdata
);

    // Deliberately unreset so loaded tables survive a pipeline reset.
    logic [OUT_BITS-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_array.sv
// rtl/lut_neuron_array.sv - array of LUT neurons with a 2-stage valid/ready lookup pipeline and table-load FSM
module lut_neuron_array
    import lut_neuron_array_pkg::*;
#(
    parameter  int NUM_NEURONS = 16,
    parameter  int FANIN       = 4,
    parameter  int IN_BITS     = 2,
    parameter  int OUT_BITS    = 2,
    localparam int ADDR_W      = FANIN * IN_BITS,
    localparam int NID_W       = clog2(NUM_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            cfg_start,
    input  logic                            cfg_we,
    input  logic [NID_W-1:0]                cfg_neuron,
    input  logic [ADDR_W-1:0]               cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_wdata,
    input  logic                            cfg_done,
    output logic                            cfg_busy
);

    state_t                            state, state_nxt;
    logic                              s1_valid;
    logic [NUM_NEURONS*ADDR_W-1:0]     s1_addr;
    logic [NUM_NEURONS*OUT_BITS-1:0]   lut_rd;
    logic                              adv, s2_en, accept, load_we;

    assign s2_en    = !out_valid || out_ready;
    assign adv      = !s1_valid || s2_en;
    // Gated by rst so the upstream sees no acceptance while reset is held.
    assign in_ready = !rst && (state == RUN) && !cfg_start && adv;
    assign accept   = in_valid && in_ready;
    assign load_we  = (state == LOAD) && cfg_we;
    assign cfg_busy = (state != RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cfg_start) state_nxt = DRAIN;
            DRAIN:   if (!s1_valid && !out_valid) state_nxt = LOAD;
            LOAD:    if (cfg_done) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (adv) begin
                s1_valid <= accept;
                if (accept) s1_addr <= in_data;
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) out_data <= lut_rd;
            end
        end
    end

    // Ids at or above NUM_NEURONS match no instance, so such writes fall away.
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        lut_neuron #(
            .ADDR_W  (ADDR_W),
            .OUT_BITS(OUT_BITS)
        ) u_lut (
            .clk  (clk),
            .we   (load_we && (cfg_neuron == NID_W'(n))),
            .waddr(cfg_addr),
            .wdata(cfg_wdata),
            .raddr(s1_addr[n*ADDR_W +: ADDR_W]),
            .rdata(lut_rd[n*OUT_BITS +: OUT_BITS])
        );
    end

endmodule

// File: tb/tb_lut_neuron_array.sv
// tb/tb_lut_neuron_array.sv - randomized self-checking bench for lut_neuron_array against a table model
module tb_lut_neuron_array;

    // Twelve neurons: ids 12..15 fit the 4-bit id port, so out-of-range writes can be driven.
    localparam int NN   = 12;
    localparam int AW   = 8;
    localparam int OB   = 2;
    localparam int NIDW = $clog2(NN);
    localparam int DW   = NN * AW;
    localparam int OW   = NN * OB;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            cfg_start = 1'b0;
    logic            cfg_we = 1'b0;
    logic [NIDW-1:0] cfg_neuron = '0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [OB-1:0]   cfg_wdata = '0;
    logic            cfg_done = 1'b0;
    logic            cfg_busy;

    lut_neuron_array #(.NUM_NEURONS(NN), .FANIN(4), .IN_BITS(2), .OUT_BITS(OB)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_start(cfg_start), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_done(cfg_done), .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    logic [OB-1:0] tbl [NN][256];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];
    int            acc_cyc[$];
    int            out_cyc[$];
    bit            accepted;
    logic          smp_in_ready, smp_out_valid, smp_cfg_busy;
    logic [OW-1:0] smp_out_data;

    function automatic logic [OW-1:0] model_out(input logic [DW-1:0] d);
        logic [OW-1:0] r;
        r = '0;
        for (int n = 0; n < NN; n++) r[n*OB +: OB] = tbl[n][d[n*AW +: AW]];
        return r;
    endfunction

    function automatic logic [DW-1:0] beat(input int mode, input int k);
        logic [DW-1:0] d;
        d = '0;
        for (int n = 0; n < NN; n++) begin
            case (mode)
                0:       d[n*AW +: AW] = AW'($urandom);
                1:       d[n*AW +: AW] = AW'((k + 37 * n) % 256);
                default: d[n*AW +: AW] = '0;
            endcase
        end
        return d;
    endfunction

    // One clock: sample at negedge, log handshakes, then return 1 time unit after posedge.
    task automatic cycle();
        @(negedge clk);
        smp_in_ready  = in_ready;
        smp_out_valid = out_valid;
        smp_out_data  = out_data;
        smp_cfg_busy  = cfg_busy;
        accepted      = in_valid && in_ready;
        if (accepted) begin
            exp_q.push_back(model_out(in_data));
            acc_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_q();
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); out_cyc.delete();
    endtask

    task automatic stream(input int count, input int mode);
        int sent;
        int guard;
        sent = 0;
        guard = 0;
        in_data = beat(mode, 0);
        in_valid = 1'b1;
        while (sent < count && guard < 2000) begin
            cycle();
            guard++;
            if (accepted) begin
                sent++;
                in_data = beat(mode, sent);
            end
        end
        in_valid = 1'b0;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 100) begin
            cycle();
            guard++;
        end
    endtask

    task automatic enter_load();
        int guard;
        guard = 0;
        cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        while (got_q.size() < exp_q.size() && guard < 100) begin
            cycle();
            guard++;
        end
        if (guard >= 100) begin
            tests++; failed++;
            $display("FAIL enter_load: drain timed out, got %0d outputs, required %0d", got_q.size(), exp_q.size());
        end
        repeat (3) cycle();
    endtask

    task automatic cfg_write(input int n, input int a, input logic [OB-1:0] d, input bit done);
        cfg_we     = 1'b1;
        cfg_neuron = NIDW'(n);
        cfg_addr   = AW'(a);
        cfg_wdata  = d;
        cfg_done   = done;
        cycle();
        cfg_we   = 1'b0;
        cfg_done = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        in_valid = 1'b1;
        in_data = beat(0, 0);
        repeat (2) cycle();
        tests++; if (smp_out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b required 0", smp_out_valid); end
        tests++; if (smp_out_data !== '0) begin failed++; $display("FAIL reset_out_data: got %h required 0", smp_out_data); end
        tests++; if (smp_in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready: got %b required 0", smp_in_ready); end
        tests++; if (smp_cfg_busy !== 1'b0) begin failed++; $display("FAIL reset_cfg_busy: got %b required 0", smp_cfg_busy); end
        rst = 1'b0;
        in_valid = 1'b0;
        cycle();
        tests++; if (smp_in_ready !== 1'b1) begin failed++; $display("FAIL post_reset_in_ready: got %b required 1", smp_in_ready); end
    endtask

    task automatic test_xor_load();
        logic [OB-1:0] want;
        clear_q();
        enter_load();
        for (int n = 0; n < NN; n++) begin
            for (int a = 0; a < 256; a++) begin
                tbl[n][a] = OB'((a ^ n) & 3);
                cfg_write(n, a, tbl[n][a], 1'b0);
            end
        end
        cfg_done = 1'b1;
        cycle();
        cfg_done = 1'b0;
        clear_q();
        in_data = {NN{8'h1B}};
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && got_q.size() == 0; i++) cycle();
        tests++;
        if (got_q.size() != 1) begin
            failed++; $display("FAIL xor_count: got %0d outputs required 1", got_q.size());
        end else begin
            for (int n = 0; n < NN; n++) begin
                want = OB'(3 ^ (n & 3));
                tests++;
                if (got_q[0][n*OB +: OB] !== want) begin
                    failed++; $display("FAIL xor_neuron%0d: got %b required %b", n, got_q[0][n*OB +: OB], want);
                end
            end
            tests++;
            if (out_cyc[0] - acc_cyc[0] != 2) begin
                failed++; $display("FAIL xor_latency: got %0d cycles required 2", out_cyc[0] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bubbles;
        clear_q();
        stream(64, 0);
        tests++;
        if (got_q.size() != 64) begin failed++; $display("FAIL b2b_count: got %0d required 64", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        bubbles = 0;
        for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] - out_cyc[i-1] != 1) bubbles++;
        for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 1) bubbles++;
        tests++;
        if (bubbles != 0) begin failed++; $display("FAIL b2b_bubbles: got %0d required 0", bubbles); end
        tests++;
        if (out_cyc.size() > 0 && out_cyc[0] - acc_cyc[0] != 2) begin
            failed++; $display("FAIL b2b_latency: got %0d required 2", out_cyc[0] - acc_cyc[0]);
        end
    endtask

    task automatic test_stall();
        int sent;
        int guard;
        int bad_rdy;
        int bad_dat;
        clear_q();
        sent = 0;
        guard = 0;
        bad_rdy = 0;
        bad_dat = 0;
        in_valid = 1'b1;
        in_data = beat(0, 0);
        while (sent < 40 && guard < 500) begin
            out_ready = !(guard >= 10 && guard < 15);
            cycle();
            if (guard >= 10 && guard < 15) begin
                if (smp_in_ready !== 1'b0) bad_rdy++;
                if (!smp_out_valid || smp_out_data !== exp_q[got_q.size()]) bad_dat++;
            end
            guard++;
            if (accepted) begin
                sent++;
                in_data = beat(0, sent);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) cycle();
        tests++; if (bad_rdy != 0) begin failed++; $display("FAIL stall_in_ready: %0d cycles high, required 0", bad_rdy); end
        tests++; if (bad_dat != 0) begin failed++; $display("FAIL stall_hold: %0d cycles unstable, required 0", bad_dat); end
        tests++; if (got_q.size() != 40) begin failed++; $display("FAIL stall_count: got %0d required 40", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL stall_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cfg_drain();
        clear_q();
        in_valid = 1'b1;
        in_data = beat(0, 0);
        cycle();
        in_data = beat(0, 1);
        cycle();
        in_valid = 1'b0;
        cfg_start = 1'b1;
        out_ready = 1'b0;
        cycle();
        cfg_start = 1'b0;
        out_ready = 1'b1;
        cycle();
        tests++; if (smp_cfg_busy !== 1'b1) begin failed++; $display("FAIL drain_busy: got %b required 1", smp_cfg_busy); end
        for (int i = 0; i < 50 && got_q.size() < 2; i++) cycle();
        tests++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            failed++; $display("FAIL drain_count: got %0d delivered of %0d accepted, required 2 of 2", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL drain_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
            end
        end
        repeat (3) cycle();
        tbl[3][0] = 2'b10;
        cfg_write(3, 0, 2'b10, 1'b1);
        cycle();
        tests++; if (smp_cfg_busy !== 1'b0) begin failed++; $display("FAIL done_busy: got %b required 0", smp_cfg_busy); end
        clear_q();
        stream(1, 2);
        tests++;
        if (got_q.size() != 1) begin
            failed++; $display("FAIL reload_count: got %0d required 1", got_q.size());
        end else begin
            tests++;
            if (got_q[0][3*OB +: OB] !== 2'b10) begin failed++; $display("FAIL reload_n3: got %b required 10", got_q[0][3*OB +: OB]); end
            tests++;
            if (got_q[0] !== exp_q[0]) begin failed++; $display("FAIL reload_all: got %h required %h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_ignored_writes();
        int n;
        int a;
        for (int i = 0; i < 16; i++) begin
            n = $urandom_range(NN - 1, 0);
            a = $urandom_range(255, 0);
            cfg_write(n, a, ~tbl[n][a], 1'b0);
        end
        clear_q();
        enter_load();
        for (int i = 0; i < 16; i++) cfg_write(NN + (i % (16 - NN)), $urandom_range(255, 0), OB'($urandom), 1'b0);
        cfg_done = 1'b1;
        cycle();
        cfg_done = 1'b0;
        clear_q();
        stream(256, 1);
        tests++; if (got_q.size() != 256) begin failed++; $display("FAIL ignored_count: got %0d required 256", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL ignored_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_in_load();
        clear_q();
        enter_load();
        tbl[0][5]    = ~tbl[0][5];    cfg_write(0, 5, tbl[0][5], 1'b0);
        tbl[4][100]  = ~tbl[4][100];  cfg_write(4, 100, tbl[4][100], 1'b0);
        tbl[11][255] = ~tbl[11][255]; cfg_write(11, 255, tbl[11][255], 1'b0);
        #3 rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rstload_out_valid: got %b required 0", out_valid); end
        tests++; if (cfg_busy !== 1'b0) begin failed++; $display("FAIL rstload_busy: got %b required 0", cfg_busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        tests++; if (smp_in_ready !== 1'b1) begin failed++; $display("FAIL rstload_in_ready: got %b required 1", smp_in_ready); end
        clear_q();
        stream(256, 1);
        tests++; if (got_q.size() != 256) begin failed++; $display("FAIL retain_count: got %0d required 256", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL retain_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_xor_load();
        test_back_to_back();
        test_stall();
        test_cfg_drain();
        test_ignored_writes();
        test_reset_in_load();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, failed);
        $fatal(1);
    end

endmodule
